// File: rtl/rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_ctrl
// Description : Control FSM for a right-to-left binary modular exponentiation
//               datapath built around a Montgomery multiplier (MMM).
//               Sequences three phases: map into the Montgomery domain, one
//               square/multiply round per exponent bit (LSB first), and remap
//               out of the domain. A start/busy/eoc handshake allows
//               back-to-back operations without a reset.
//
// Parameters  : EXP_WIDTH - exponent bits = number of MMM rounds (>= 1)
//               MMM_STEPS - clock cycles per multiplier pass (>= 2)
//
// Ports       : clk      in   clock, rising edge
//               rstb     in   asynchronous active-low reset
//               ena      in   clock enable (all registers hold when low)
//               start    in   start request, honoured in IDLE or DONE
//               exp_e    in   exponent, captured on the accepted start
//               rst_mmm  out  active-low multiplier clear
//               ld_a     out  load multiplier operand register
//               ld_r     out  load result register
//               lock1    out  result-path update enable
//               lock2    out  square-path update enable
//               sel1     out  operand mux: 00 map, 01 round, 10 remap
//               sel2     out  second operand mux
//               busy     out  high in every state except IDLE and DONE
//               eoc      out  end of computation, high only in DONE
//
// Options     : RSA_MODEXP_EARLY_EXIT_EN - when defined, rounds stop after the
//               most significant set exponent bit (none for a zero exponent).
//
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_modexp_ctrl #(
    parameter int EXP_WIDTH = 10,
    parameter int MMM_STEPS = 11
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 ena,
    input  logic                 start,
    input  logic [EXP_WIDTH-1:0] exp_e,
    output logic                 rst_mmm,
    output logic                 ld_a,
    output logic                 ld_r,
    output logic                 lock1,
    output logic                 lock2,
    output logic [1:0]           sel1,
    output logic                 sel2,
    output logic                 busy,
    output logic                 eoc
);

    localparam int c_STEP_W  = (MMM_STEPS > 1) ? $clog2(MMM_STEPS) : 1;
    localparam int c_ROUND_W = $clog2(EXP_WIDTH) + 1;

    localparam logic [c_STEP_W-1:0]  c_STEP_LAST  = c_STEP_W'(MMM_STEPS - 1);
    localparam logic [c_ROUND_W-1:0] c_ROUND_LAST = c_ROUND_W'(EXP_WIDTH - 1);

    localparam logic [3:0] c_ST_IDLE       = 4'd0;
    localparam logic [3:0] c_ST_PRE_MAP    = 4'd1;
    localparam logic [3:0] c_ST_MAP        = 4'd2;
    localparam logic [3:0] c_ST_POST_MAP   = 4'd3;
    localparam logic [3:0] c_ST_PRE_MMM    = 4'd4;
    localparam logic [3:0] c_ST_MMM        = 4'd5;
    localparam logic [3:0] c_ST_POST_MMM   = 4'd6;
    localparam logic [3:0] c_ST_PRE_REMAP  = 4'd7;
    localparam logic [3:0] c_ST_REMAP      = 4'd8;
    localparam logic [3:0] c_ST_POST_REMAP = 4'd9;
    localparam logic [3:0] c_ST_DONE       = 4'd10;

    logic [3:0]           r_state;
    logic [3:0]           w_next_state;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [c_STEP_W-1:0]  r_step;
    logic [c_ROUND_W-1:0] r_round;
    logic                 w_step_last;
    logic                 w_e0;

    assign w_step_last = (r_step == c_STEP_LAST);
    assign w_e0        = r_exp[0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE, c_ST_DONE:
                w_next_state = start ? c_ST_PRE_MAP : r_state;
            c_ST_PRE_MAP:
                w_next_state = c_ST_MAP;
            c_ST_MAP:
                w_next_state = w_step_last ? c_ST_POST_MAP : c_ST_MAP;
            c_ST_POST_MAP: begin
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                // A zero exponent needs no rounds: the mapped one is the result.
                w_next_state = (r_exp == '0) ? c_ST_PRE_REMAP : c_ST_PRE_MMM;
`else
                w_next_state = c_ST_PRE_MMM;
`endif
            end
            c_ST_PRE_MMM:
                w_next_state = c_ST_MMM;
            c_ST_MMM:
                w_next_state = w_step_last ? c_ST_POST_MMM : c_ST_MMM;
            c_ST_POST_MMM: begin
                // r_round still holds the index of the round just finished.
`ifdef RSA_MODEXP_EARLY_EXIT_EN
                if ((r_round == c_ROUND_LAST) || ((r_exp >> 1) == '0))
`else
                if (r_round == c_ROUND_LAST)
`endif
                    w_next_state = c_ST_PRE_REMAP;
                else
                    w_next_state = c_ST_PRE_MMM;
            end
            c_ST_PRE_REMAP:
                w_next_state = c_ST_REMAP;
            c_ST_REMAP:
                w_next_state = w_step_last ? c_ST_POST_REMAP : c_ST_REMAP;
            c_ST_POST_REMAP:
                w_next_state = c_ST_DONE;
            default:
                w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State, exponent and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= c_ST_IDLE;
            r_exp   <= '0;
            r_step  <= '0;
            r_round <= '0;
        end else if (ena) begin
            r_state <= w_next_state;
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_exp   <= exp_e;
                        r_step  <= '0;
                        r_round <= '0;
                    end
                end
                c_ST_MAP, c_ST_MMM, c_ST_REMAP:
                    r_step <= r_step + 1'b1;
                c_ST_POST_MAP, c_ST_POST_REMAP:
                    r_step <= '0;
                c_ST_POST_MMM: begin
                    // Next round works on the next exponent bit.
                    r_step  <= '0;
                    r_exp   <= r_exp >> 1;
                    r_round <= r_round + 1'b1;
                end
                default: begin
                    r_step <= r_step;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (pure function of the current state)
    // ------------------------------------------------------------------
    always_comb begin
        rst_mmm = 1'b0;
        ld_a    = 1'b0;
        ld_r    = 1'b0;
        lock1   = 1'b0;
        lock2   = 1'b0;
        sel1    = 2'b00;
        sel2    = 1'b0;
        busy    = 1'b0;
        eoc     = 1'b0;
        case (r_state)
            c_ST_PRE_MAP, c_ST_MAP: begin
                rst_mmm = 1'b1; ld_a = 1'b1; lock1 = 1'b1; lock2 = 1'b1;
                busy    = 1'b1;
            end
            c_ST_POST_MAP: begin
                rst_mmm = 1'b1; ld_r = 1'b1; lock1 = 1'b1; lock2 = 1'b1;
                busy    = 1'b1;
            end
            c_ST_PRE_MMM, c_ST_MMM, c_ST_POST_MMM: begin
                // Multiply into the result only when the current bit is set.
                rst_mmm = 1'b1;
                ld_a    = (r_state == c_ST_PRE_MMM);
                ld_r    = (r_state == c_ST_POST_MMM);
                lock1   = w_e0;
                lock2   = 1'b1;
                sel1    = 2'b01;
                sel2    = 1'b1;
                busy    = 1'b1;
            end
            c_ST_PRE_REMAP, c_ST_REMAP, c_ST_POST_REMAP: begin
                rst_mmm = 1'b1;
                ld_a    = (r_state == c_ST_PRE_REMAP);
                ld_r    = (r_state == c_ST_POST_REMAP);
                lock1   = 1'b1;
                sel1    = 2'b10;
                sel2    = 1'b1;
                busy    = 1'b1;
            end
            c_ST_DONE: begin
                // ld_r stays low so the final result is held.
                rst_mmm = 1'b1; lock1 = 1'b1; sel1 = 2'b10; sel2 = 1'b1;
                eoc     = 1'b1;
            end
            default: begin
                rst_mmm = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_modexp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_modexp_ctrl
// Description : Directed self-checking bench for rsa_modexp_ctrl. Instance A
//               uses default parameters, instance B uses EXP_WIDTH=4,
//               MMM_STEPS=3. Expected latencies follow (R+2)(S+2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_modexp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstb, ena;
    logic       a_start, b_start;
    logic [9:0] a_exp;
    logic [3:0] b_exp;
    logic       a_rst_mmm, a_ld_a, a_ld_r, a_lock1, a_lock2, a_sel2, a_busy, a_eoc;
    logic [1:0] a_sel1;
    logic       b_rst_mmm, b_ld_a, b_ld_r, b_lock1, b_lock2, b_sel2, b_busy, b_eoc;
    logic [1:0] b_sel1;

    int checks = 0;
    int errors = 0;
    int n;

    // Per-round lock1 record of instance A (one sample per POST_MMM cycle).
    logic [15:0] rec_bits;
    int          rec_idx;

    rsa_modexp_ctrl u_dut_a (
        .clk(clk), .rstb(rstb), .ena(ena), .start(a_start), .exp_e(a_exp),
        .rst_mmm(a_rst_mmm), .ld_a(a_ld_a), .ld_r(a_ld_r), .lock1(a_lock1),
        .lock2(a_lock2), .sel1(a_sel1), .sel2(a_sel2), .busy(a_busy), .eoc(a_eoc)
    );

    rsa_modexp_ctrl #(.EXP_WIDTH(4), .MMM_STEPS(3)) u_dut_b (
        .clk(clk), .rstb(rstb), .ena(ena), .start(b_start), .exp_e(b_exp),
        .rst_mmm(b_rst_mmm), .ld_a(b_ld_a), .ld_r(b_ld_r), .lock1(b_lock1),
        .lock2(b_lock2), .sel1(b_sel1), .sel2(b_sel2), .busy(b_busy), .eoc(b_eoc)
    );

    // {rst_mmm, ld_a, ld_r, lock1, lock2, sel1, sel2, busy, eoc}
    localparam logic [9:0] c_VEC_IDLE    = 10'b00000_00_0_00;
    localparam logic [9:0] c_VEC_PRE_MAP = 10'b11011_00_0_10;
    localparam logic [9:0] c_VEC_MMM_E1  = 10'b10011_01_1_10;
    localparam logic [9:0] c_VEC_DONE    = 10'b10010_10_1_01;

    function automatic logic [9:0] a_vec();
        return {a_rst_mmm, a_ld_a, a_ld_r, a_lock1, a_lock2, a_sel1, a_sel2, a_busy, a_eoc};
    endfunction

    function automatic logic [9:0] b_vec();
        return {b_rst_mmm, b_ld_a, b_ld_r, b_lock1, b_lock2, b_sel1, b_sel2, b_busy, b_eoc};
    endfunction

    always @(negedge clk) begin
        if (a_busy && a_ld_r && a_sel1 == 2'b01) begin
            if (rec_idx < 16) rec_bits[rec_idx] = a_lock1;
            rec_idx++;
        end
    end

    task automatic step_a();
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic a_start_op(input logic [9:0] e);
        a_start = 1'b1;
        a_exp   = e;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        n       = 0;
    endtask

    task automatic a_wait_eoc(input int limit);
        while (a_eoc !== 1'b1 && n < limit) step_a();
    endtask

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b1; a_start = 1'b0; b_start = 1'b0;
        a_exp = '0; b_exp = '0; rec_idx = 0; rec_bits = '0;
        #1;
        checks++;
        if (a_vec() !== c_VEC_IDLE) begin
            errors++; $display("FAIL reset_a: got %b expected %b", a_vec(), c_VEC_IDLE);
        end
        checks++;
        if (b_vec() !== c_VEC_IDLE) begin
            errors++; $display("FAIL reset_b: got %b expected %b", b_vec(), c_VEC_IDLE);
        end
        @(negedge clk);
        rstb = 1'b1;
        repeat (3) step_a();
        checks++;
        if (a_vec() !== c_VEC_IDLE) begin
            errors++; $display("FAIL idle_hold: got %b expected %b", a_vec(), c_VEC_IDLE);
        end
    endtask

    task automatic test_basic();
        rec_idx = 0;
        a_start_op(10'h2A5);
        checks++;
        if (a_vec() !== c_VEC_PRE_MAP) begin
            errors++; $display("FAIL basic_pre_map: got %b expected %b", a_vec(), c_VEC_PRE_MAP);
        end
        a_wait_eoc(400);
        checks++;
        if (n !== 156) begin
            errors++; $display("FAIL basic_latency: got %0d expected 156", n);
        end
        checks++;
        if (rec_idx !== 10) begin
            errors++; $display("FAIL basic_rounds: got %0d expected 10", rec_idx);
        end
        checks++;
        if (rec_bits[9:0] !== 10'b1010100101) begin
            errors++; $display("FAIL basic_lock1_seq: got %b expected 1010100101", rec_bits[9:0]);
        end
        repeat (3) step_a();
        checks++;
        if (a_vec() !== c_VEC_DONE) begin
            errors++; $display("FAIL done_hold: got %b expected %b", a_vec(), c_VEC_DONE);
        end
    endtask

    task automatic test_ena_freeze();
        logic [9:0] snap;
        a_start_op(10'h3FF);
        while (n < 18) step_a();
        snap = a_vec();
        checks++;
        if (snap !== c_VEC_MMM_E1) begin
            errors++; $display("FAIL freeze_in_mmm: got %b expected %b", snap, c_VEC_MMM_E1);
        end
        ena = 1'b0;
        repeat (7) begin
            step_a();
            checks++;
            if (a_vec() !== snap) begin
                errors++; $display("FAIL freeze_hold: got %b expected %b at edge %0d", a_vec(), snap, n);
            end
        end
        ena = 1'b1;
        a_wait_eoc(400);
        checks++;
        if (n !== 163) begin
            errors++; $display("FAIL freeze_latency: got %0d expected 163", n);
        end
    endtask

    task automatic test_async_reset();
        int exp_lat;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
        exp_lat = 39;
`else
        exp_lat = 156;
`endif
        a_start_op(10'h3FF);
        while (n < 70) step_a();
        checks++;
        if (a_busy !== 1'b1) begin
            errors++; $display("FAIL areset_pre_busy: got %b expected 1", a_busy);
        end
        #2 rstb = 1'b0;
        #1;
        checks++;
        if (a_vec() !== c_VEC_IDLE) begin
            errors++; $display("FAIL areset_immediate: got %b expected %b", a_vec(), c_VEC_IDLE);
        end
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) step_a();
        checks++;
        if (a_vec() !== c_VEC_IDLE) begin
            errors++; $display("FAIL areset_stays_idle: got %b expected %b", a_vec(), c_VEC_IDLE);
        end
        a_start_op(10'd1);
        a_wait_eoc(400);
        checks++;
        if (n !== exp_lat) begin
            errors++; $display("FAIL areset_restart_latency: got %0d expected %0d", n, exp_lat);
        end
    endtask

    task automatic test_back_to_back();
        a_start_op(10'h2A5);
        a_start = 1'b1;
        repeat (20) step_a();
        a_start = 1'b0;
        a_wait_eoc(400);
        checks++;
        if (n !== 156) begin
            errors++; $display("FAIL busy_start_ignored: got %0d expected 156", n);
        end
        rec_idx = 0;
        a_start_op(10'h201);
        checks++;
        if ({a_busy, a_eoc} !== 2'b10) begin
            errors++; $display("FAIL b2b_restart: got busy,eoc=%b expected 10", {a_busy, a_eoc});
        end
        a_wait_eoc(400);
        checks++;
        if (n !== 156) begin
            errors++; $display("FAIL b2b_latency: got %0d expected 156", n);
        end
        checks++;
        if (rec_bits[9:0] !== 10'h201 || rec_idx !== 10) begin
            errors++; $display("FAIL b2b_new_exp: got %b/%0d expected %b/10", rec_bits[9:0], rec_idx, 10'h201);
        end
    endtask

    task automatic test_small_params();
        int m, cur, runs, bad, ri;
        logic [3:0] lk;
        m = 0; cur = 0; runs = 0; bad = 0; ri = 0; lk = '0;
        b_start = 1'b1;
        b_exp   = 4'b1011;
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0;
        while (b_eoc !== 1'b1 && m < 100) begin
            @(posedge clk);
            m++;
            @(negedge clk);
            if (b_busy && b_rst_mmm && !b_ld_a && !b_ld_r && b_sel1 == 2'b01) begin
                cur++;
            end else if (cur != 0) begin
                if (cur != 3) bad++;
                runs++;
                cur = 0;
            end
            if (b_busy && b_ld_r && b_sel1 == 2'b01) begin
                if (ri < 4) lk[ri] = b_lock1;
                ri++;
            end
        end
        checks++;
        if (m !== 30) begin
            errors++; $display("FAIL small_latency: got %0d expected 30", m);
        end
        checks++;
        if (runs !== 4 || bad !== 0) begin
            errors++; $display("FAIL small_mmm_passes: got %0d passes %0d bad expected 4 passes 0 bad", runs, bad);
        end
        checks++;
        if (lk !== 4'b1011 || ri !== 4) begin
            errors++; $display("FAIL small_lock1_seq: got %b/%0d expected 1011/4", lk, ri);
        end
    endtask

    task automatic test_early_exit();
        int lat_101, lat_0;
`ifdef RSA_MODEXP_EARLY_EXIT_EN
        lat_101 = 65; lat_0 = 26;
`else
        lat_101 = 156; lat_0 = 156;
`endif
        a_start_op(10'b101);
        a_wait_eoc(400);
        checks++;
        if (n !== lat_101) begin
            errors++; $display("FAIL exit_exp101: got %0d expected %0d", n, lat_101);
        end
        a_start_op(10'd0);
        a_wait_eoc(400);
        checks++;
        if (n !== lat_0) begin
            errors++; $display("FAIL exit_exp0: got %0d expected %0d", n, lat_0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ena_freeze();
        test_async_reset();
        test_back_to_back();
        test_small_params();
        test_early_exit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
